// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pipe_pkg
// Description : Shared types and constants for the 5-stage MIPS pipeline.
//               Holds the decoded control bundle, ALU operation classes,
//               primary opcodes and well-known register indices.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

    // ALU operation class driven by the decode control unit
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Well-known register indices
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

    // Decoded control bundle carried down the pipe
    typedef struct packed {
        logic       reg_dst;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       jal;
        logic [1:0] alu_op;
    } ctrl_t;

    // A bubble carries no side effects: every control bit cleared
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage : mips_pipe_pkg
`default_nettype wire

// File: rtl/mips_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : mips_hazard_detect
// Description : Combinational load-use hazard detector. Flags a decode
//               instruction that reads the destination of a load sitting in
//               EX. The rt compare is opcode-agnostic; false stalls on
//               instructions that do not read rt are accepted.
// Ports       : i_ex_valid, i_ex_mem_read, i_ex_rt  - state of the EX slot
//               i_id_valid, i_id_rs, i_id_rt        - state of the ID slot
//               i_flush                             - decode instruction killed
//               o_load_use                          - raw hazard condition
//               o_stall                             - freeze request to IF/ID
// Revision    : 1.0 - initial release
// ============================================================================
module mips_hazard_detect
    import mips_pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             i_ex_valid,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_flush,
    output logic             o_load_use,
    output logic             o_stall
);

    logic w_rt_nonzero;
    logic w_src_match;

    // $zero is never a real dependency: writes to it are discarded
    assign w_rt_nonzero = (i_ex_rt != REG_W'(REG_ZERO));
    assign w_src_match  = (i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt);

    assign o_load_use = i_ex_valid & i_ex_mem_read & w_rt_nonzero
                      & i_id_valid & w_src_match;

    // A killed decode instruction must not freeze fetch
    assign o_stall = o_load_use & ~i_flush;

endmodule : mips_hazard_detect
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register of the 5-stage MIPS core. Registers
//               the decoded control bundle, operands, immediate and PC+4,
//               resolves the destination register (rd / rt / $ra) and
//               inserts a bubble on a load-use hazard or a flush.
//               Edge priority: flush > hold > load-use bubble > load.
// Ports       : clk, rst_n (async active-low)
//               id_*        - decode-stage instruction fields
//               flush_i     - taken branch/jump kills the decode instruction
//               hold_i      - downstream stall, freeze this register
//               stall_o     - load-use freeze request for PC and IF/ID
//               ex_*        - registered copies into EX
//               ex_write_reg- resolved destination index
//               bubble_cnt, flush_cnt - performance counters
// Options     : ID_EX_PERF_CNT_EN - enables the two counters; otherwise
//               they are tied to zero with no flops.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int RA_REG = REG_RA
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_reg_dst,
    input  logic              id_jump,
    input  logic              id_branch,
    input  logic              id_mem_read,
    input  logic              id_mem_to_reg,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic              id_jal,
    input  logic [1:0]        id_alu_op,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic              stall_o,
    output logic              ex_valid,
    output logic              ex_reg_dst,
    output logic              ex_jump,
    output logic              ex_branch,
    output logic              ex_mem_read,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic              ex_jal,
    output logic [1:0]        ex_alu_op,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic [REG_W-1:0]  ex_write_reg,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       flush_cnt
);

    // ------------------------------------------------------------------
    // Registered EX state
    // ------------------------------------------------------------------
    logic              r_valid;
    ctrl_t             r_ctrl;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc_plus4;
    logic [REG_W-1:0]  r_write_reg;

    // ------------------------------------------------------------------
    // Combinational decode-side signals
    // ------------------------------------------------------------------
    ctrl_t             w_id_ctrl;
    logic [REG_W-1:0]  w_write_reg;
    logic              w_load_use;
    logic              w_lu_bubble;
    logic              w_bubble;
    logic              w_load;

    assign w_id_ctrl = '{
        reg_dst:    id_reg_dst,
        jump:       id_jump,
        branch:     id_branch,
        mem_read:   id_mem_read,
        mem_to_reg: id_mem_to_reg,
        mem_write:  id_mem_write,
        alu_src:    id_alu_src,
        reg_write:  id_reg_write,
        jal:        id_jal,
        alu_op:     id_alu_op
    };

    // JAL links into $ra regardless of the rd/rt encoding
    always_comb begin
        w_write_reg = id_rt;
        if (id_jal) begin
            w_write_reg = REG_W'(RA_REG);
        end else if (id_reg_dst) begin
            w_write_reg = id_rd;
        end
    end

    mips_hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard (
        .i_ex_valid    (r_valid),
        .i_ex_mem_read (r_ctrl.mem_read),
        .i_ex_rt       (r_rt),
        .i_id_valid    (id_valid),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .i_flush       (flush_i),
        .o_load_use    (w_load_use),
        .o_stall       (stall_o)
    );

    // A hold masks the load-use bubble: the hazard is re-evaluated once
    // the hold lifts, with the load still sitting in EX.
    assign w_lu_bubble = ~flush_i & ~hold_i & w_load_use;
    assign w_bubble    = flush_i | w_lu_bubble;
    assign w_load      = ~flush_i & ~hold_i & ~w_load_use;

    // ------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_ctrl      <= CTRL_BUBBLE;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_pc_plus4  <= '0;
            r_write_reg <= '0;
        end else if (w_bubble) begin
            r_valid     <= 1'b0;
            r_ctrl      <= CTRL_BUBBLE;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_pc_plus4  <= '0;
            r_write_reg <= '0;
        end else if (w_load) begin
            // Control bits load even for an invalid slot; EX/MEM gate
            // side effects on ex_valid.
            r_valid     <= id_valid;
            r_ctrl      <= w_id_ctrl;
            r_rs        <= id_rs;
            r_rt        <= id_rt;
            r_rs_data   <= id_rs_data;
            r_rt_data   <= id_rt_data;
            r_imm       <= id_imm;
            r_pc_plus4  <= id_pc_plus4;
            r_write_reg <= w_write_reg;
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_lu_bubble) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
            if (flush_i) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`else
    assign bubble_cnt = '0;
    assign flush_cnt  = '0;
`endif

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign ex_valid      = r_valid;
    assign ex_reg_dst    = r_ctrl.reg_dst;
    assign ex_jump       = r_ctrl.jump;
    assign ex_branch     = r_ctrl.branch;
    assign ex_mem_read   = r_ctrl.mem_read;
    assign ex_mem_to_reg = r_ctrl.mem_to_reg;
    assign ex_mem_write  = r_ctrl.mem_write;
    assign ex_alu_src    = r_ctrl.alu_src;
    assign ex_reg_write  = r_ctrl.reg_write;
    assign ex_jal        = r_ctrl.jal;
    assign ex_alu_op     = r_ctrl.alu_op;
    assign ex_rs         = r_rs;
    assign ex_rt         = r_rt;
    assign ex_rs_data    = r_rs_data;
    assign ex_rt_data    = r_rt_data;
    assign ex_imm        = r_imm;
    assign ex_pc_plus4   = r_pc_plus4;
    assign ex_write_reg  = r_write_reg;

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed self-checking bench for id_ex_stage: reset, the
//               destination mux, load-use stall/bubble, $zero exemption,
//               flush priority, hold, and the optional counters
//               (ID_EX_PERF_CNT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
    import mips_pipe_pkg::*;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    logic              clk;
    logic              rst_n;
    logic              id_valid, id_reg_dst, id_jump, id_branch, id_mem_read;
    logic              id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write, id_jal;
    logic [1:0]        id_alu_op;
    logic [REG_W-1:0]  id_rs, id_rt, id_rd;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm, id_pc_plus4;
    logic              flush_i, hold_i;
    logic              stall_o;
    logic              ex_valid, ex_reg_dst, ex_jump, ex_branch, ex_mem_read;
    logic              ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_jal;
    logic [1:0]        ex_alu_op;
    logic [REG_W-1:0]  ex_rs, ex_rt, ex_write_reg;
    logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4;
    logic [31:0]       bubble_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .RA_REG (31)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_reg_dst    (id_reg_dst),
        .id_jump       (id_jump),
        .id_branch     (id_branch),
        .id_mem_read   (id_mem_read),
        .id_mem_to_reg (id_mem_to_reg),
        .id_mem_write  (id_mem_write),
        .id_alu_src    (id_alu_src),
        .id_reg_write  (id_reg_write),
        .id_jal        (id_jal),
        .id_alu_op     (id_alu_op),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .id_rs_data    (id_rs_data),
        .id_rt_data    (id_rt_data),
        .id_imm        (id_imm),
        .id_pc_plus4   (id_pc_plus4),
        .flush_i       (flush_i),
        .hold_i        (hold_i),
        .stall_o       (stall_o),
        .ex_valid      (ex_valid),
        .ex_reg_dst    (ex_reg_dst),
        .ex_jump       (ex_jump),
        .ex_branch     (ex_branch),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_mem_write  (ex_mem_write),
        .ex_alu_src    (ex_alu_src),
        .ex_reg_write  (ex_reg_write),
        .ex_jal        (ex_jal),
        .ex_alu_op     (ex_alu_op),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_rs_data    (ex_rs_data),
        .ex_rt_data    (ex_rt_data),
        .ex_imm        (ex_imm),
        .ex_pc_plus4   (ex_pc_plus4),
        .ex_write_reg  (ex_write_reg),
        .bubble_cnt    (bubble_cnt),
        .flush_cnt     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an empty decode slot
    task automatic clr_id();
        id_valid = 0; id_reg_dst = 0; id_jump = 0; id_branch = 0;
        id_mem_read = 0; id_mem_to_reg = 0; id_mem_write = 0;
        id_alu_src = 0; id_reg_write = 0; id_jal = 0; id_alu_op = ALUOP_ADD;
        id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_pc_plus4 = 0;
    endtask

    // lw rt, imm(rs)
    task automatic put_lw(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
        clr_id();
        id_valid = 1; id_mem_read = 1; id_mem_to_reg = 1; id_alu_src = 1;
        id_reg_write = 1; id_rs = rs; id_rt = rt; id_imm = imm;
    endtask

    // R-type add rd, rs, rt
    task automatic put_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        clr_id();
        id_valid = 1; id_reg_dst = 1; id_reg_write = 1; id_alu_op = ALUOP_RTYPE;
        id_rs = rs; id_rt = rt; id_rd = rd;
    endtask

    initial begin
        rst_n = 1'b1; flush_i = 0; hold_i = 0;
        clr_id();

        // ---------------- asynchronous reset mid-cycle ----------------
        put_add(5'd1, 5'd2, 5'd3);
        id_rs_data = 32'h1111_0000;
        tick();
        chk("pre_rst_reg_write", ex_reg_write, 1'b1);
        chk("pre_rst_rs_data", ex_rs_data, 32'h1111_0000);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_reg_write", ex_reg_write, 1'b0);
        chk("rst_valid", ex_valid, 1'b0);
        chk("rst_write_reg", ex_write_reg, 5'd0);
        chk("rst_rs_data", ex_rs_data, 32'd0);
        chk("rst_alu_op", ex_alu_op, 2'b00);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_bubble_cnt", bubble_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
        #2 rst_n = 1'b1;

        // ---------------- destination mux ----------------
        clr_id();
        id_valid = 1; id_jal = 1; id_jump = 1; id_reg_write = 1;
        id_rd = 5'd5; id_rt = 5'd2; id_pc_plus4 = 32'h0040_0010;
        tick();
        chk("jal_write_reg", ex_write_reg, 5'd31);
        chk("jal_ex_jal", ex_jal, 1'b1);
        chk("jal_pc_plus4", ex_pc_plus4, 32'h0040_0010);

        put_add(5'd4, 5'd6, 5'd12);
        tick();
        chk("rtype_write_reg", ex_write_reg, 5'd12);
        chk("rtype_alu_op", ex_alu_op, ALUOP_RTYPE);

        clr_id();
        id_valid = 1; id_alu_src = 1; id_reg_write = 1;
        id_rs = 5'd3; id_rt = 5'd7; id_rd = 5'd0; id_imm = 32'hFFFF_FFF0;
        tick();
        chk("addi_write_reg", ex_write_reg, 5'd7);
        chk("addi_imm", ex_imm, 32'hFFFF_FFF0);

        // id_valid=0: controls still load, slot marked invalid
        clr_id();
        id_mem_write = 1; id_rt = 5'd4;
        tick();
        chk("inval_valid", ex_valid, 1'b0);
        chk("inval_mem_write", ex_mem_write, 1'b1);

        // ---------------- load-use stall ----------------
        put_lw(5'd29, 5'd8, 32'h10);
        tick();
        chk("lw_mem_read", ex_mem_read, 1'b1);
        chk("lw_ex_rt", ex_rt, 5'd8);
        put_add(5'd8, 5'd9, 5'd10);
        id_rs_data = 32'hCAFE_0001;
        #1;
        chk("lu_stall", stall_o, 1'b1);
        tick();
        chk("lu_bubble_valid", ex_valid, 1'b0);
        chk("lu_bubble_reg_write", ex_reg_write, 1'b0);
        chk("lu_bubble_write_reg", ex_write_reg, 5'd0);
        chk("lu_stall_dropped", stall_o, 1'b0);
`ifdef ID_EX_PERF_CNT_EN
        chk("lu_bubble_cnt", bubble_cnt, 32'd1);
`endif
        tick();
        chk("lu_add_valid", ex_valid, 1'b1);
        chk("lu_add_write_reg", ex_write_reg, 5'd10);
        chk("lu_add_rs_data", ex_rs_data, 32'hCAFE_0001);

        // ---------------- $zero exemption / false stall ----------------
        put_lw(5'd29, 5'd0, 32'h4);
        tick();
        clr_id();
        id_valid = 1; id_rs = 5'd0; id_rt = 5'd0;
        #1;
        chk("zero_no_stall", stall_o, 1'b0);
        put_lw(5'd29, 5'd9, 32'h8);
        tick();
        chk("lw9_loaded", ex_rt, 5'd9);
        clr_id();
        id_valid = 1; id_mem_write = 1; id_alu_src = 1; id_rs = 5'd29; id_rt = 5'd9;
        #1;
        chk("sw_rt_stall", stall_o, 1'b1);
        tick();
        chk("sw_bubble_valid", ex_valid, 1'b0);
        tick();
        chk("sw_loaded_mem_write", ex_mem_write, 1'b1);

        // ---------------- flush beats load-use ----------------
        put_lw(5'd29, 5'd8, 32'h0);
        tick();
        put_add(5'd8, 5'd1, 5'd2);
        flush_i = 1;
        #1;
        chk("flush_stall_masked", stall_o, 1'b0);
        tick();
        flush_i = 0;
        chk("flush_bubble_valid", ex_valid, 1'b0);
        chk("flush_bubble_mem_read", ex_mem_read, 1'b0);
`ifdef ID_EX_PERF_CNT_EN
        chk("flush_cnt", flush_cnt, 32'd1);
        chk("flush_bubble_cnt", bubble_cnt, 32'd2);
`endif

        // ---------------- hold ----------------
        put_lw(5'd1, 5'd11, 32'h44);
        id_rs_data = 32'h0000_ABCD;
        tick();
        hold_i = 1;
        put_add(5'd11, 5'd3, 5'd14);
        #1;
        chk("hold_lu_stall", stall_o, 1'b1);
        tick();
        put_add(5'd3, 5'd4, 5'd15);
        id_rs_data = 32'h5555_5555;
        tick();
        clr_id();
        id_valid = 1; id_jal = 1; id_pc_plus4 = 32'h77;
        tick();
        chk("hold_rt", ex_rt, 5'd11);
        chk("hold_mem_read", ex_mem_read, 1'b1);
        chk("hold_imm", ex_imm, 32'h44);
        chk("hold_rs_data", ex_rs_data, 32'h0000_ABCD);
        chk("hold_write_reg", ex_write_reg, 5'd11);
`ifdef ID_EX_PERF_CNT_EN
        chk("hold_bubble_cnt", bubble_cnt, 32'd2);
        chk("hold_flush_cnt", flush_cnt, 32'd1);
`endif
        hold_i = 0;
        put_add(5'd2, 5'd3, 5'd13);
        id_rt_data = 32'h0BAD_F00D;
        tick();
        chk("release_write_reg", ex_write_reg, 5'd13);
        chk("release_mem_read", ex_mem_read, 1'b0);
        chk("release_rt_data", ex_rt_data, 32'h0BAD_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_id_ex_stage
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage MIPS core; sits directly downstream of the decode control unit.
- Registers the decoded control bundle, register-file operands, immediate and PC+4 into the EX stage.
- Resolves the destination register (rd / rt / $ra).
- Contains load-use hazard detection: requests an IF/ID freeze and inserts a bubble.
- Honours branch/jump flush and a downstream hold.

Parameters:
- DATA_W, 32, width of operand, immediate and PC fields
- REG_W, 5, register index width
- RA_REG, 31, destination index forced for JAL

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_reg_dst, id_jump, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write, id_jal  in  1 each  decoded control bits
- id_alu_op  in  2  ALU operation class
- id_rs, id_rt, id_rd  in  REG_W  instruction register fields
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate (funct in [5:0])
- id_pc_plus4  in  DATA_W  PC+4 of the decode instruction
- flush_i  in  1  taken branch/jump: kill the decode instruction
- hold_i  in  1  downstream stall: freeze this register
- stall_o  out  1  load-use hazard: freeze PC and IF/ID
- ex_valid, ex_* (each id_* control bit, alu_op, rs, rt, rs_data, rt_data, imm, pc_plus4)  out  as input  registered copies
- ex_write_reg  out  REG_W  resolved destination index
- bubble_cnt, flush_cnt  out  32  performance counters (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): every ex_* output, ex_write_reg, ex_valid and both counters are 0. stall_o is combinational and reads 0 because ex_mem_read=0.
- Hazard (combinational): load_use = ex_valid & ex_mem_read & (ex_rt != 0) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt)).
  - The rt comparison is made regardless of opcode. Conservative false stalls are accepted.
- stall_o = load_use & ~flush_i.
- Destination: write_reg = RA_REG if id_jal; else id_rd if id_reg_dst; else id_rt. It is registered into ex_write_reg.
- Update priority at each rising edge, highest first:
  - 1. flush_i: load a bubble.
  - 2. hold_i: retain every field.
  - 3. load_use: load a bubble.
  - 4. Otherwise: load all id_* fields, with ex_valid = id_valid.
- Bubble: ex_valid and every control bit = 0; ex_alu_op = 00; data and index fields = 0; ex_write_reg = 0.
- Latency: exactly 1 cycle from ID inputs to ex_* outputs. There is no combinational path from id_* to ex_*.
- If id_valid=0, the control bits are still loaded, but ex_valid=0. The EX/MEM stages gate writes with ex_valid.
- flush_i together with load_use: the flush wins, stall_o=0 and a bubble is loaded. The killed instruction must not freeze fetch.
- hold_i together with load_use: the register holds and stall_o=1. Upstream stays frozen, and the hazard re-evaluates after the hold.
- A load-use stall lasts exactly 1 cycle. After the bubble, ex_mem_read=0, so load_use drops.
- Reset mid-stall: all outputs clear immediately. The first instruction after reset is loaded normally.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined:
  - bubble_cnt increments on every edge where a load-use bubble is loaded.
  - flush_cnt increments on every edge where flush_i loads a bubble.
  - Neither counter increments while the register is held.
  - Both counters wrap at 2^32 and reset to 0.
- When not defined: no counter flops; bubble_cnt and flush_cnt are tied to 0. Ports are unchanged.

Decomposition:
- Package mips_pipe_pkg holds:
  - ctrl_t struct (the nine control bits plus alu_op)
  - ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_RTYPE=10, ALUOP_OR=11
  - opcode constants
  - REG_ZERO=0, REG_RA=31
  - CTRL_BUBBLE constant (all zeros)
- Sub-module mips_hazard_detect: purely combinational. It produces load_use and stall_o from the ex_* and id_* indices. It is reused later by the forwarding unit.

Test Plan:
- Reset: set rst_n=0 mid-cycle with ex_reg_write=1 -> all outputs 0 without waiting for a clock edge; stall_o=0.
- Load-use: lw $t0 (rt=8, mem_read=1) in EX, then add with rs=8 in ID:
  - stall_o=1 for 1 cycle;
  - the next edge gives ex_valid=0 and ex_reg_write=0;
  - the following edge loads the add with ex_write_reg=id_rd.
- $zero exemption and false-stall check:
  - lw with rt=0, then an instruction with rs=0 -> stall_o=0.
  - lw rt=9, then sw with rt=9 -> stall_o=1.
- Flush priority: flush_i=1 together with a load-use condition -> stall_o=0; the next edge gives a bubble. With ID_EX_PERF_CNT_EN, flush_cnt=1 and bubble_cnt=0.
- Destination mux:
  - jal (id_jal=1, id_rd=5) -> ex_write_reg=31.
  - R-type rd=12 -> 12.
  - addi rt=7 -> 7.
- Hold: hold_i=1 for 3 cycles while the id_* inputs change -> ex_* unchanged and counters unchanged; the release edge loads the current id_* values.
